// File: rtl/fft_frame_tx_pkg.sv
// Shared types and helpers for the FFT transmit-side framer.
package fft_frame_tx_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } frame_tx_state_t;

    function automatic int unsigned frame_ptr_w(input int unsigned fft_size);
        return $clog2(fft_size);
    endfunction

endpackage

// File: rtl/fft_frame_tx_if.sv
// Upstream sample handshake plus downstream frame stream of the framer.
interface fft_frame_tx_if;
    import fft_frame_tx_pkg::*;

    logic [SAMPLE_W-1:0] s_re;
    logic [SAMPLE_W-1:0] s_im;
    logic                s_valid;
    logic                s_ready;
    logic                s_flush;
    logic [SAMPLE_W-1:0] dout_re;
    logic [SAMPLE_W-1:0] dout_im;
    logic                dout_valid;
    logic                frame_start;

    modport master (
        output s_re, s_im, s_valid, s_flush,
        input  s_ready, dout_re, dout_im, dout_valid, frame_start
    );

    modport slave (
        input  s_re, s_im, s_valid, s_flush,
        output s_ready, dout_re, dout_im, dout_valid, frame_start
    );

endinterface

// File: rtl/fft_frame_tx_pingpong_ram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
module fft_frame_tx_pingpong_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     wr_bank,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     rd_bank,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [2*DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Read register doubles as the output register, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/fft_frame_tx.sv
// Buffers bursty upstream samples into ping-pong frames and emits each frame
// as an unbroken run of FFT_SIZE valid cycles.
module fft_frame_tx
    import fft_frame_tx_pkg::*;
#(
    parameter int unsigned FFT_SIZE = 32,
    parameter int unsigned MIN_GAP  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    fft_frame_tx_if.slave  bus
);

    localparam int unsigned PW = frame_ptr_w(FFT_SIZE);
    localparam logic [PW-1:0] LAST = PW'(FFT_SIZE - 1);
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    logic            ready_en;
    logic [PW-1:0]   wr_ptr;
    logic            wr_bank;
    logic [1:0]      full;
    logic [1:0]      full_d;
    logic            s_ready;
    logic            accept;
    logic            wr_last;

    frame_tx_state_t state;
    logic            rd_bank;
    logic [PW-1:0]   rd_ptr;
    logic [GW-1:0]   gap_cnt;
    logic            rd_en;
    logic            rd_last;
    logic            dout_valid;
    logic            frame_start;

    complex_t        wr_sample;
    complex_t        rd_sample;

    // ready_en keeps s_ready low during reset and rises on the first clock after.
    assign s_ready     = ready_en & ~full[wr_bank];
    assign accept      = bus.s_valid & s_ready & ~bus.s_flush;
    assign wr_last     = accept && (wr_ptr == LAST);
    assign rd_en       = (state == EMIT);
    assign rd_last     = rd_en && (rd_ptr == LAST);
    assign wr_sample   = '{re: bus.s_re, im: bus.s_im};

    always_comb begin
        full_d = full;
        if (wr_last) begin
            full_d[wr_bank] = 1'b1;
        end
        if (rd_last) begin
            full_d[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
            wr_ptr   <= '0;
            wr_bank  <= 1'b0;
            full     <= '0;
        end else begin
            ready_en <= 1'b1;
            full     <= full_d;
            if (bus.s_flush) begin
                wr_ptr <= '0;
            end else if (accept) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end
        end
    end

    // Reader FSM; the final GAP cycle also performs the IDLE check so the
    // idle run between frames is exactly MIN_GAP cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_bank     <= 1'b0;
            rd_ptr      <= '0;
            gap_cnt     <= '0;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            dout_valid  <= rd_en;
            frame_start <= rd_en && (rd_ptr == '0);
            case (state)
                IDLE: begin
                    rd_ptr <= '0;
                    if (full[rd_bank]) begin
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (rd_ptr == LAST) begin
                        rd_bank <= ~rd_bank;
                        rd_ptr  <= '0;
                        gap_cnt <= '0;
                        if (MIN_GAP > 0) begin
                            state <= GAP;
                        end else if (full[~rd_bank]) begin
                            state <= EMIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
                GAP: begin
                    rd_ptr <= '0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= full[rd_bank] ? EMIT : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fft_frame_tx_pingpong_ram #(
        .DEPTH (FFT_SIZE),
        .WIDTH ($bits(complex_t))
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_bank (wr_bank),
        .wr_addr (wr_ptr),
        .wr_data (wr_sample),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rd_ptr),
        .rd_data (rd_sample)
    );

    assign bus.s_ready     = s_ready;
    assign bus.dout_re     = rd_sample.re;
    assign bus.dout_im     = rd_sample.im;
    assign bus.dout_valid  = dout_valid;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Directed bench for fft_frame_tx: one instance with MIN_GAP=0, one with MIN_GAP=3.
module tb_fft_frame_tx;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fft_frame_tx_if bus0 ();
    fft_frame_tx_if bus1 ();

    fft_frame_tx #(.FFT_SIZE(N), .MIN_GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fft_frame_tx #(.FFT_SIZE(N), .MIN_GAP(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        int          t;
        logic        v;
        logic [15:0] re;
        logic [15:0] im;
        logic        fs;
        logic        rdy;
    } ent_t;

    ent_t        lg0[$];
    ent_t        lg1[$];
    int          nchk = 0;
    int          nerr = 0;
    int          tk = 0;
    bit          log_en = 0;
    int          n_acc[2];
    int          n_tgt[2];
    logic [15:0] base[2];
    bit          tog[2];
    bit          fl[2];
    bit          wacc[2];
    int          last_set_tk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Log outputs at the negedge, then drive the next cycle's inputs.
    task automatic tick();
        logic        v;
        logic [15:0] d;
        @(negedge clk);
        tk++;
        if (log_en) begin
            lg0.push_back('{t: tk, v: bus0.dout_valid, re: bus0.dout_re, im: bus0.dout_im,
                            fs: bus0.frame_start, rdy: bus0.s_ready});
            lg1.push_back('{t: tk, v: bus1.dout_valid, re: bus1.dout_re, im: bus1.dout_im,
                            fs: bus1.frame_start, rdy: bus1.s_ready});
        end
        for (int s = 0; s < 2; s++) begin
            if (wacc[s]) n_acc[s]++;
        end
        v = (n_acc[0] < n_tgt[0]) && (!tog[0] || tk[0] == 1'b0);
        d = base[0] + 16'(n_acc[0]);
        if (fl[0]) begin
            bus0.s_flush = 1'b1;
            bus0.s_valid = 1'b1;
            bus0.s_re    = 16'hDEAD;
            bus0.s_im    = 16'h2153;
            wacc[0]      = 1'b0;
            fl[0]        = 1'b0;
        end else begin
            bus0.s_flush = 1'b0;
            bus0.s_valid = v;
            bus0.s_re    = d;
            bus0.s_im    = -d;
            wacc[0]      = v && bus0.s_ready;
            if (wacc[0] && n_acc[0] == N - 1) last_set_tk = tk;
        end
        v = (n_acc[1] < n_tgt[1]) && (!tog[1] || tk[0] == 1'b0);
        d = base[1] + 16'(n_acc[1]);
        bus1.s_flush = 1'b0;
        bus1.s_valid = v;
        bus1.s_re    = d;
        bus1.s_im    = -d;
        wacc[1]      = v && bus1.s_ready;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic start_log();
        lg0.delete();
        lg1.delete();
        log_en = 1'b1;
    endtask

    task automatic src(input int s, input int tgt, input logic [15:0] b, input bit t);
        n_acc[s] = 0;
        n_tgt[s] = tgt;
        base[s]  = b;
        tog[s]   = t;
    endtask

    // Expect nfr frames of consecutive values starting at b, im = -re.
    task automatic check_frames(input int side, input int nfr, input logic [15:0] b,
                                input int gap, input bit do_gap, input string tag);
        ent_t        q[$];
        ent_t        e;
        int          i;
        int          g;
        int          extra;
        logic [15:0] xre;
        logic [15:0] xim;
        if (side == 0) q = lg0;
        else q = lg1;
        i = 0;
        while (i < q.size() && !q[i].v) i++;
        chk({tag, ".found"}, 32'(i < q.size()), 32'd1);
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < N; k++) begin
                e   = (i < q.size()) ? q[i] : '0;
                xre = b + 16'(f * N + k);
                xim = -xre;
                chk($sformatf("%s.f%0d.s%0d.valid", tag, f, k), 32'(e.v), 32'd1);
                chk($sformatf("%s.f%0d.s%0d.re", tag, f, k), 32'(e.re), 32'(xre));
                chk($sformatf("%s.f%0d.s%0d.im", tag, f, k), 32'(e.im), 32'(xim));
                chk($sformatf("%s.f%0d.s%0d.fs", tag, f, k), 32'(e.fs), 32'(k == 0));
                i++;
            end
            if (f < nfr - 1) begin
                g = 0;
                while (i < q.size() && !q[i].v) begin
                    g++;
                    i++;
                end
                if (do_gap) chk($sformatf("%s.gap%0d", tag, f), 32'(g), 32'(gap));
            end
        end
        extra = 0;
        while (i < q.size()) begin
            if (q[i].v) extra++;
            i++;
        end
        chk({tag, ".extra_valid"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int  idx;
        bit  found;
        int  nv;

        for (int s = 0; s < 2; s++) begin
            n_acc[s] = 0;
            n_tgt[s] = 0;
            base[s]  = '0;
            tog[s]   = 1'b0;
            fl[s]    = 1'b0;
            wacc[s]  = 1'b0;
        end
        bus0.s_valid = 1'b0; bus0.s_flush = 1'b0; bus0.s_re = '0; bus0.s_im = '0;
        bus1.s_valid = 1'b0; bus1.s_flush = 1'b0; bus1.s_re = '0; bus1.s_im = '0;

        // Reset state
        ticks(2);
        chk("rst.dout_valid", 32'(bus0.dout_valid), 32'd0);
        chk("rst.frame_start", 32'(bus0.frame_start), 32'd0);
        chk("rst.dout_re", 32'(bus0.dout_re), 32'd0);
        chk("rst.dout_im", 32'(bus0.dout_im), 32'd0);
        chk("rst.s_ready0", 32'(bus0.s_ready), 32'd0);
        chk("rst.s_ready1", 32'(bus1.s_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel.s_ready0", 32'(bus0.s_ready), 32'd1);
        chk("rel.s_ready1", 32'(bus1.s_ready), 32'd1);

        // Continuous 64 samples: two back-to-back frames, plus first-frame latency
        start_log();
        src(0, 2 * N, 16'h0000, 1'b0);
        ticks(120);
        log_en = 1'b0;
        check_frames(0, 2, 16'h0000, 0, 1'b1, "cont");
        idx = 0;
        while (idx < lg0.size() && !lg0[idx].v) idx++;
        chk("latency", 32'((idx < lg0.size()) ? lg0[idx].t - last_set_tk : -1), 32'd3);

        // s_valid toggling every other cycle
        start_log();
        src(0, N, 16'h0200, 1'b1);
        ticks(120);
        log_en = 1'b0;
        check_frames(0, 1, 16'h0200, 0, 1'b0, "toggle");

        // 96 samples into both: dut0 stalls upstream, dut1 shows MIN_GAP=3
        start_log();
        src(0, 3 * N, 16'h0400, 1'b0);
        src(1, 3 * N, 16'h0800, 1'b0);
        ticks(180);
        log_en = 1'b0;
        check_frames(1, 3, 16'h0800, 3, 1'b1, "gap3");
        check_frames(0, 3, 16'h0400, 0, 1'b0, "stall");
        idx = 0;
        while (idx < lg0.size() && !(lg0[idx].v && lg0[idx].re == 16'h041F)) idx++;
        chk("stall.s31_found", 32'(idx > 0 && idx < lg0.size()), 32'd1);
        if (idx > 0 && idx < lg0.size()) begin
            chk("stall.ready_rise", 32'(lg0[idx].rdy), 32'd1);
            chk("stall.ready_low", 32'(lg0[idx-1].rdy), 32'd0);
        end

        // Flush after 10 samples (flush tick also carries a dropped sample)
        start_log();
        src(0, 10, 16'h0AA0, 1'b0);
        ticks(15);
        fl[0] = 1'b1;
        tick();
        src(0, N, 16'h1000, 1'b0);
        ticks(80);
        log_en = 1'b0;
        check_frames(0, 1, 16'h1000, 0, 1'b0, "flush");

        // Reset in the middle of emission at sample 15
        src(0, N, 16'h0300, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (bus0.dout_valid && bus0.dout_re == 16'h030F) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid.reach_s15", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid.dout_valid", 32'(bus0.dout_valid), 32'd0);
        chk("mid.frame_start", 32'(bus0.frame_start), 32'd0);
        chk("mid.dout_re", 32'(bus0.dout_re), 32'd0);
        chk("mid.s_ready", 32'(bus0.s_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid.rel_s_ready", 32'(bus0.s_ready), 32'd1);
        start_log();
        ticks(60);
        log_en = 1'b0;
        nv = 0;
        foreach (lg0[j]) if (lg0[j].v) nv++;
        chk("mid.no_stale", 32'(nv), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
